// File: rtl/hdmi_i2c_cfg.sv
// hdmi_i2c_cfg: selects the HDMI channel on the KC705 I2C switch, then writes an
// externally supplied register table to the ADV7511 over I2C.
module hdmi_i2c_cfg #(
    parameter int          CLK_HZ   = 200000000,
    parameter int          I2C_HZ   = 100000,
    parameter logic [6:0]  MUX_ADDR = 7'h74,
    parameter logic [7:0]  MUX_CHAN = 8'h20,
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter logic [7:0]  NUM_REGS = 8'd40
) (
    input  logic        sys0_clk,
    input  logic        sys0_rstn,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        i2c_scl_o,
    output logic        i2c_sda_oe,
    input  logic        i2c_sda_i,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic [7:0]  err_idx
);
    localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int QW   = $clog2(QDIV);

    typedef enum logic [2:0] {S_IDLE, S_PRESTOP, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE} state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitn;
    logic [1:0]    bidx;
    logic [7:0]    txn;
    logic [15:0]   data_q;
    logic          tick, pend, last_byte, accept;
    logic [7:0]    cur_byte;

    assign tick      = qcnt == QW'(QDIV - 1);
    assign pend      = tick && q == 2'd3;
    assign accept    = state == S_IDLE && start;
    assign busy      = state != S_IDLE && state != S_DONE;
    assign tbl_addr  = txn;
    // Transaction 0 is the two-byte switch write; table entries use three bytes.
    assign last_byte = bidx == (txn == 8'd0 ? 2'd1 : 2'd2);
    assign cur_byte  = bidx == 2'd0 ? {(txn == 8'd0 ? MUX_ADDR : DEV_ADDR), 1'b0} :
                       bidx == 2'd1 ? (txn == 8'd0 ? MUX_CHAN : data_q[15:8]) : data_q[7:0];

    always_ff @(posedge sys0_clk) begin
        if (!sys0_rstn) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            q        <= '0;
            bitn     <= '0;
            bidx     <= '0;
            txn      <= '0;
            data_q   <= '0;
            done     <= 1'b0;
            nack_err <= 1'b0;
            err_idx  <= '0;
        end else begin
            state <= state_n;
            qcnt  <= (busy && !tick) ? qcnt + 1'b1 : '0;
            if (busy && tick) q <= q + 2'd1;
            if (state == S_BYTE && pend) bitn <= bitn + 3'd1;
            if (state == S_START && pend) bidx <= 2'd0;
            if (state == S_ACK && pend) bidx <= bidx + 2'd1;
            if (state == S_GAP && pend) begin
                txn    <= txn + 8'd1;
                data_q <= tbl_data;
            end
            if (state == S_STOP && state_n == S_DONE) done <= 1'b1;
            if (state == S_ACK && tick && q == 2'd2 && i2c_sda_i) begin
                nack_err <= 1'b1;
                err_idx  <= txn;
            end
            if (accept) begin
                txn      <= '0;
                done     <= 1'b0;
                nack_err <= 1'b0;
                err_idx  <= '0;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = S_PRESTOP;
            S_PRESTOP: if (pend) state_n = S_START;
            S_START:   if (pend) state_n = S_BYTE;
            S_BYTE:    if (pend && bitn == 3'd7) state_n = S_ACK;
            S_ACK:     if (pend) state_n = (nack_err || last_byte) ? S_STOP : S_BYTE;
            S_STOP:    if (pend) state_n = (nack_err || txn == NUM_REGS) ? S_DONE : S_GAP;
            S_GAP:     if (pend) state_n = S_START;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        i2c_scl_o  = 1'b1;
        i2c_sda_oe = 1'b0;
        case (state)
            S_PRESTOP, S_STOP: begin
                i2c_scl_o  = q != 2'd0;
                i2c_sda_oe = q < 2'd2;
            end
            S_START: begin
                i2c_scl_o  = q != 2'd3;
                i2c_sda_oe = q[1];
            end
            S_BYTE: begin
                i2c_scl_o  = q[0] ^ q[1];
                i2c_sda_oe = ~cur_byte[3'd7 - bitn];
            end
            S_ACK:   i2c_scl_o = q[0] ^ q[1];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_hdmi_i2c_cfg.sv
// tb_hdmi_i2c_cfg: directed runs against an I2C slave model that decodes the bus
// and checks each byte against a queue of expected bytes.
module tb_hdmi_i2c_cfg;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_start = 1'b0, b_start = 1'b0;
    logic [7:0]  a_addr, b_addr, a_err, b_err;
    logic [15:0] a_tbl = '0;
    logic        a_scl, a_oe, a_sdi, a_busy, a_done, a_nack;
    logic        b_scl, b_oe, b_sdi, b_busy, b_done, b_nack;
    logic        sel = 1'b0;
    logic        pull = 1'b0;

    int passed = 0, total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ta_q[$];
    int nack_at = -1, nbytes = 0, stops = 0;

    always #5 clk = ~clk;

    hdmi_i2c_cfg #(.CLK_HZ(4000000), .I2C_HZ(100000), .NUM_REGS(8'd2)) dut_a (
        .sys0_clk(clk), .sys0_rstn(rstn), .start(a_start), .tbl_addr(a_addr), .tbl_data(a_tbl),
        .i2c_scl_o(a_scl), .i2c_sda_oe(a_oe), .i2c_sda_i(a_sdi), .busy(a_busy), .done(a_done),
        .nack_err(a_nack), .err_idx(a_err));

    hdmi_i2c_cfg #(.CLK_HZ(4000000), .I2C_HZ(100000), .NUM_REGS(8'd0)) dut_b (
        .sys0_clk(clk), .sys0_rstn(rstn), .start(b_start), .tbl_addr(b_addr), .tbl_data(16'h0000),
        .i2c_scl_o(b_scl), .i2c_sda_oe(b_oe), .i2c_sda_i(b_sdi), .busy(b_busy), .done(b_done),
        .nack_err(b_nack), .err_idx(b_err));

    assign a_sdi = ~(a_oe | (pull & ~sel));
    assign b_sdi = ~(b_oe | (pull & sel));

    always @(posedge clk) a_tbl <= a_addr == 8'd0 ? 16'h4110 : a_addr == 8'd1 ? 16'h9803 : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slave model on the selected bus: START/STOP detection, bit decode, ACK/NACK.
    logic s_scl, s_sda, p_scl = 1'b1, p_sda = 1'b1, in_txn = 1'b0;
    logic [7:0] sh = '0;
    int bitcnt = 0, txn_bytes = 0;
    always @(negedge clk) begin
        s_scl = sel ? b_scl : a_scl;
        s_sda = ~((sel ? b_oe : a_oe) | pull);
        if (s_scl && p_scl && p_sda && !s_sda) begin
            in_txn = 1'b1;
            bitcnt = 0;
            txn_bytes = 0;
        end else if (s_scl && p_scl && !p_sda && s_sda) begin
            if (in_txn && txn_bytes > 0) begin
                stops++;
                if (ta_q.size() > 0) chk("tbl_addr_gap", a_addr, ta_q.pop_front());
            end
            in_txn = 1'b0;
            bitcnt = 0;
        end else if (s_scl && !p_scl) begin
            if (bitcnt < 8) sh = {sh[6:0], s_sda};
            bitcnt++;
        end else if (!s_scl && p_scl) begin
            if (bitcnt == 8) begin
                if (exp_q.size() > 0) chk("bus_byte", sh, exp_q.pop_front());
                else chk("extra_byte", exp_q.size(), 1);
                pull = nbytes != nack_at;
                nbytes++;
                txn_bytes++;
            end else if (bitcnt == 9) begin
                pull = 1'b0;
                bitcnt = 0;
            end
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    task automatic set_start(input bit s, input logic v);
        if (s) b_start = v;
        else a_start = v;
    endtask

    // Pulse start, then run until done; p1/p2 are extra start pulses at cycle n.
    task automatic go(input bit s, input int p1, input int p2, output int n);
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        n = 1;
        chk("busy_rise", s ? b_busy : a_busy, 1'b1);
        chk("prestop_q0", {s ? b_scl : a_scl, s ? b_oe : a_oe}, 2'b01);
        chk("done_clear", s ? b_done : a_done, 1'b0);
        while (n < 20000 && !(s ? b_done : a_done)) begin
            @(negedge clk);
            n++;
            set_start(s, n == p1 || n == p2);
        end
        set_start(s, 1'b0);
    endtask

    task automatic push_full();
        exp_q = {8'he8, 8'h20, 8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03};
        ta_q = {8'd0, 8'd1};
    endtask

    initial begin
        int n, s0;
        repeat (3) @(negedge clk);
        chk("rst_scl", a_scl, 1'b1);
        chk("rst_sda_oe", a_oe, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_nack", a_nack, 1'b0);
        chk("rst_err_idx", a_err, 8'd0);
        chk("rst_tbl_addr", a_addr, 8'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        push_full();
        go(1'b0, 500, 3240, n);
        chk("full_cycles", n, 3241);
        chk("full_busy_low", a_busy, 1'b0);
        chk("full_nack", a_nack, 1'b0);
        repeat (5) @(negedge clk);
        chk("done_held", {a_busy, a_done}, 2'b01);
        chk("full_leftover", exp_q.size() + ta_q.size(), 0);

        exp_q = {8'he8, 8'h20, 8'h72};
        nack_at = nbytes + 2;
        s0 = stops;
        go(1'b0, 0, 0, n);
        chk("nack_cycles", n, 1321);
        chk("nack_err", a_nack, 1'b1);
        chk("nack_idx", a_err, 8'd1);
        chk("nack_stops", stops - s0, 2);
        chk("nack_leftover", exp_q.size(), 0);
        nack_at = -1;
        repeat (20) @(negedge clk);

        exp_q = {8'he8, 8'h20};
        go(1'b1, 0, 0, n);
        chk("zero_cycles", n, 841);
        chk("zero_nack", b_nack, 1'b0);
        chk("zero_leftover", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        sel = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("clear_nack", {a_nack, a_err}, 9'd0);
        repeat (134) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midbit_rst", {a_scl, a_oe, a_busy, a_done}, 4'b1000);
        repeat (20) @(negedge clk);

        push_full();
        go(1'b0, 0, 0, n);
        chk("rerun_cycles", n, 3241);
        chk("rerun_nack", a_nack, 1'b0);
        repeat (5) @(negedge clk);
        chk("rerun_leftover", exp_q.size() + ta_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hdmi_i2c_cfg.md
Name: hdmi_i2c_cfg

Overview:
- Configuration sequencer for the HDMI transmitter (ADV7511) that sits behind the KC705 I2C switch.
- On a start pulse it releases the bus, selects the HDMI channel on the switch, then writes an externally supplied table of register/value pairs over I2C.
- It drives the top-level i2c_scl / i2c_sda pins and reports busy, done and NACK error status to the surrounding logic.

Parameters:
- CLK_HZ, 200000000, sys0_clk frequency in Hz.
- I2C_HZ, 100000, SCL bit rate. QDIV = CLK_HZ/(4*I2C_HZ) clocks per quarter-bit. QDIV is 500 at the defaults; QDIV >= 2 is required.
- MUX_ADDR, 7'h74, 7-bit address of the I2C switch.
- MUX_CHAN, 8'h20, channel-select byte written to the switch.
- DEV_ADDR, 7'h39, 7-bit address of the HDMI transmitter.
- NUM_REGS, 8'd40, number of table entries to write (0 to 255).

Ports:
- sys0_clk  in  1  sole clock.
- sys0_rstn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a configuration run; ignored while busy=1.
- tbl_addr  out  8  table index being requested.
- tbl_data  in  16  {reg[15:8], val[7:0]}; valid one cycle after tbl_addr changes.
- i2c_scl_o  out  1  SCL level (1 = high/released).
- i2c_sda_oe  out  1  1 = drive SDA low, 0 = release.
- i2c_sda_i  in  1  sampled SDA pin level.
- busy  out  1  run in progress.
- done  out  1  level; last run finished (successfully or not).
- nack_err  out  1  level; last run aborted on a NACK.
- err_idx  out  8  transaction index of the NACK: 0 = switch write, k = table entry k-1.

Behaviour:
- Reset (sys0_rstn=0 at a clock edge): every state register clears.
  - i2c_scl_o=1, i2c_sda_oe=0, busy=0, done=0, nack_err=0, err_idx=0, tbl_addr=0.
  - A reset mid-byte abandons the transfer immediately. The bus is recovered by the leading STOP of the next run.
- Quarter timer: counts 0..QDIV-1 while busy. Every bit-level phase lasts exactly 4 quarters, q0..q3.
- start accepted in IDLE: busy=1 on the next cycle; done, nack_err and err_idx clear on the same cycle.
- States: IDLE -> PRESTOP -> START -> BYTE -> ACK -> (BYTE | STOP) -> GAP -> START ... -> DONE -> IDLE.
- PRESTOP / STOP:
  - q0: SCL low, SDA low.
  - q1: SCL high, SDA low.
  - q2 and q3: SCL high, SDA released.
- START:
  - q0 and q1: SCL high, SDA released.
  - q2: SCL high, SDA low.
  - q3: SCL low, SDA low.
- BYTE: 8 bits, MSB first. For each bit:
  - q0: SCL low, SDA set to the bit (0 drives low, 1 releases).
  - q1 and q2: SCL high.
  - q3: SCL low.
- ACK: SDA released in every quarter; SCL follows the same pattern as a data bit. i2c_sda_i is sampled on the last cycle of q2; 0 = ACK, 1 = NACK.
- GAP: 4 quarters with SCL high and SDA released, between consecutive transactions.
- Transaction 0 (switch write): START, {MUX_ADDR,0}, MUX_CHAN, STOP.
- Transaction k (k = 1..NUM_REGS): START, {DEV_ADDR,0}, tbl_data[15:8], tbl_data[7:0], STOP.
  - tbl_addr = k-1 is presented during the preceding GAP.
  - tbl_data is captured once at the end of that GAP and held for the whole transaction.
- After the final STOP the block enters DONE for one cycle: done=1, busy=0 on the next cycle, then IDLE.
- NUM_REGS=0: only transaction 0 runs, then DONE.
- NACK: the ACK phase completes, then STOP runs, then DONE (no GAP).
  - nack_err=1 and err_idx = current transaction index.
  - Remaining entries are skipped.
- done and nack_err hold until the next accepted start or reset.
- start arriving in the same cycle that DONE is entered is ignored; a start is accepted only in IDLE.
- No clock stretching: SCL is never read back.
- Quarter counts:
  - Switch transaction: 80 quarters (START 4 + 2 bytes × 36 + STOP 4).
  - Register transaction: 116 quarters.
  - Run total: 4 + 80 + NUM_REGS × (4 + 116) quarters.
  - Cycles from busy rising to done rising = QDIV × that total.

Test Plan:
- CLK_HZ=4000000, I2C_HZ=100000 (QDIV=10), NUM_REGS=2, I2C slave model ACKs every byte, start pulse at cycle T -> busy=1 at T+1; done=1 and busy=0 at T+1+3240; nack_err=0; the slave log shows 74 W [20], then 39 W [r0 v0], then 39 W [r1 v1].
- Same setup, tbl_data fed from a ROM with entry0=16'h4110 and entry1=16'h9803 -> the bytes decoded on the bus are 72,41,10 and 72,98,03; tbl_addr reads 0 and then 1 during the respective GAPs.
- Slave NACKs the address byte of table entry 0 -> nack_err=1, err_idx=1, the STOP follows the NACK bit, entry 1 never appears on the bus, and done rises.
- NUM_REGS=0 -> only 74 W 20 appears; done rises 840 cycles after busy.
- Reset held low for 1 cycle in the middle of a data bit -> the next cycle shows scl_o=1, sda_oe=0, busy=0, done=0; a later start yields a full correct run beginning with PRESTOP.
- Second start pulse while busy, and start coinciding with DONE entry -> both ignored: one run only, and done stays 1 after it.
